regfile_gen2: RTL and testbench

REGFILE_GEN2 -- requirements
Module: regfile_gen2

---
 rtl/regfile_gen2.sv | 110 +++++++++++
 tb/tb_regfile_gen2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_gen2.sv
// regfile_gen2 -- 2**ADDR_W x DATA_W register file with a hardwired-zero
// register 0, one data write port, one immediate write port, two
// combinational read ports and a sequential clear engine.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-high reset (clears every register)
//   we_a/wa/wd_a   data write port A
//   we_i/wi/imm    immediate write port (imm is zero-extended)
//   ra1/rd1        read port 1 (address 0 reads 0)
//   ra2/rd2        read port 2 (address 0 returns zero-extended imm)
//   clr_req        single-cycle request to clear registers 1..DEPTH-1
//   busy           high while the clear sequence is running
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports. Without it, reads show the stored value and a
// write becomes visible right after its clock edge.
//
// Clear FSM
//   state    | meaning
//   ST_IDLE  | normal operation, writes and clr_req accepted
//   ST_CLEAR | zeroing reg[idx] each cycle, writes and clr_req ignored
module regfile_gen2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wi,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] imm_ext;
  logic              wr_a_ok;
  logic              wr_i_ok;

  assign imm_ext = DATA_W'(imm);
  assign busy    = (state == ST_CLEAR);

  // A write is accepted only in idle and never to the hardwired-zero slot.
  assign wr_a_ok = we_a && !busy && (wa != '0);
  assign wr_i_ok = we_i && !busy && (wi != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_a_ok) regs[wa] <= wd_a;
          // Placed after port A so it wins on an address collision.
          if (wr_i_ok) regs[wi] <= imm_ext;
          if (clr_req) begin
            state <= ST_CLEAR;
            idx   <= ADDR_W'(1);
          end
        end
        ST_CLEAR: begin
          regs[idx] <= '0;
          if (idx == '1) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = imm_ext;
    if (ra1 != '0) rd1 = regs[ra1];
    if (ra2 != '0) rd2 = regs[ra2];
`ifdef REGFILE_BYPASS_EN
    // wr_*_ok already excludes address 0 and the busy window.
    if (wr_a_ok && (wa == ra1)) rd1 = wd_a;
    if (wr_i_ok && (wi == ra1)) rd1 = imm_ext;
    if (wr_a_ok && (wa == ra2)) rd2 = wd_a;
    if (wr_i_ok && (wi == ra2)) rd2 = imm_ext;
`endif
  end

endmodule

// File: tb/tb_regfile_gen2.sv
module tb_regfile_gen2;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  logic        we_a, we_i, clr_req;
  logic [2:0]  wa, wi, ra1, ra2;
  logic [31:0] wd_a;
  logic [7:0]  imm;
  logic [31:0] rd1, rd2;
  logic        busy;

  regfile_gen2 dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .wa(wa), .wd_a(wd_a),
    .we_i(we_i), .wi(wi), .imm(imm),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .clr_req(clr_req), .busy(busy)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Scoreboard: stimulus pushes expected values, monitor compares.
  typedef struct {
    string       name;
    int          sel;   // 0 rd1, 1 rd2, 2 busy
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  event  chk_ev;
  int    n_chk = 0;
  int    n_fail = 0;

  initial begin
    item_t it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        it = q.pop_front();
        case (it.sel)
          0:       act = rd1;
          1:       act = rd2;
          default: act = {31'd0, busy};
        endcase
        n_chk++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    item_t it;
    #1;
    it.name = name; it.sel = sel; it.exp = exp;
    q.push_back(it);
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we_a = 0; we_i = 0; clr_req = 0;
  endtask

  task automatic write_a(input logic [2:0] a, input logic [31:0] d);
    we_a = 1; wa = a; wd_a = d;
    tick();
    we_a = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the clock stopped.
    rst = 1; idle_in();
    wa = 0; wi = 0; wd_a = 0; imm = 8'hA5; ra1 = 3; ra2 = 0;
    #2;
    chk("rst_rd1", 0, 32'h0);
    chk("rst_rd2_imm", 1, 32'h000000A5);
    chk("rst_busy", 2, 32'h0);
    ra2 = 4;
    chk("rst_rd2_reg", 1, 32'h0);
    rst = 0;
    #2;
    clk_en = 1;
    tick();

    // Basic write/read.
    write_a(3, 32'hDEADBEEF);
    ra1 = 3; ra2 = 3;
    chk("wr3_rd1", 0, 32'hDEADBEEF);
    chk("wr3_rd2", 1, 32'hDEADBEEF);

    // Writes to address 0 are discarded.
    write_a(0, 32'hFFFFFFFF);
    we_i = 1; wi = 0; imm = 8'h33;
    tick();
    we_i = 0; imm = 8'hA5;
    ra1 = 0; ra2 = 0;
    chk("r0_rd1", 0, 32'h0);
    chk("r0_rd2_imm", 1, 32'h000000A5);

    // Collision on one address: immediate port wins.
    we_a = 1; wa = 5; wd_a = 32'h11111111;
    we_i = 1; wi = 5; imm = 8'h7F;
    tick();
    idle_in();
    ra1 = 5;
    chk("collide_r5", 0, 32'h0000007F);

    // Different addresses: both land.
    we_a = 1; wa = 6; wd_a = 32'hCAFEF00D;
    we_i = 1; wi = 7; imm = 8'h3C;
    tick();
    idle_in();
    ra1 = 6; ra2 = 7;
    chk("dual_r6", 0, 32'hCAFEF00D);
    chk("dual_r7", 1, 32'h0000003C);

    // Same-cycle read of a write in flight.
    write_a(2, 32'hAAAA5555);
    we_a = 1; wa = 2; wd_a = 32'h12345678; ra1 = 2;
    we_i = 1; wi = 4; imm = 8'h5A; ra2 = 4;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd1", 0, 32'h12345678);
    chk("byp_rd2", 1, 32'h0000005A);
`else
    chk("byp_rd1", 0, 32'hAAAA5555);
    chk("byp_rd2", 1, 32'h0);
`endif
    tick();
    idle_in();
    chk("post_r2", 0, 32'h12345678);
    chk("post_r4", 1, 32'h0000005A);

    // Fill and sequential clear.
    for (int k = 1; k < 8; k++) write_a(k[2:0], 32'h10000000 + k);
    for (int k = 1; k < 8; k++) begin
      ra1 = k[2:0];
      chk("fill", 0, 32'h10000000 + k);
    end
    // Write in the same cycle as clr_req completes first.
    we_a = 1; wa = 1; wd_a = 32'h0BAD0001; clr_req = 1;
    tick();
    ra1 = 1;
    chk("clr_start_busy", 2, 32'h1);
    chk("clr_start_r1", 0, 32'h0BAD0001);
    // Hammer writes and clr_req while busy; all must be ignored.
    we_a = 1; wa = 1; wd_a = 32'hFFFFFFFF;
    we_i = 1; wi = 2; imm = 8'hEE;
    clr_req = 1;
    for (int c = 1; c < 8; c++) begin
      tick();
      if (c == 7) idle_in();
      ra1 = c[2:0];
      chk("clr_rk", 0, 32'h0);
      if (c < 7) begin
        ra2 = 3'(c + 1);
        chk("clr_next", 1, 32'h10000000 + c + 1);
      end
      chk("clr_busy", 2, (c < 7) ? 32'h1 : 32'h0);
    end
    tick();
    chk("clr_idle", 2, 32'h0);
    for (int k = 1; k < 8; k++) begin
      ra1 = k[2:0];
      chk("clr_all0", 0, 32'h0);
    end

    // Reset in the middle of a clear.
    for (int k = 1; k < 8; k++) write_a(k[2:0], 32'h20000000 + k);
    clr_req = 1;
    tick();
    clr_req = 0;
    tick();
    tick();  // idx now 3
    ra1 = 3;
    chk("mid_r3_before", 0, 32'h20000003);
    rst = 1;
    chk("mid_busy", 2, 32'h0);
    for (int k = 1; k < 8; k++) begin
      ra1 = k[2:0];
      chk("mid_rst_r", 0, 32'h0);
    end
    rst = 0;
    tick();
    tick();
    chk("mid_after_busy", 2, 32'h0);
    ra1 = 7;
    chk("mid_after_r7", 0, 32'h0);
    write_a(4, 32'h0F0F0F0F);
    ra1 = 4;
    chk("mid_after_wr", 0, 32'h0F0F0F0F);

    #2;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
